lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Memory stage of the RV32 pipeline: consumes the EX/MEM packet (ALU result, LSU flag and 4-bit LSU opcode, destination register) and produces the MEM/WB packet. Non-memory instructions pass through with one register stage. Loads and stores run a request/response transaction on the data-memory port, with byte-enable generation, store-data replication, load extraction with sign/zero extension, and misalignment detection. The stage stalls EX through `ex_ready` while a transaction is outstanding.

## Interface
- `DataWidth`, 32: datapath and memory bus width; only 32 is supported.
- `RegAddrWidth`, 5: register address width.
- `LsuOpWidth`, 4: LSU opcode width.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: EX/MEM packet valid.
- `ex_ready` out 1: stage accepts a packet this cycle.
- `ex_rd_en` in 1: instruction writes `rd`.
- `ex_rd_addr` in RegAddrWidth: destination register.
- `ex_alu_res` in DataWidth: result for non-LSU ops, effective address for LSU ops.
- `ex_lsu` in 1: packet is a load or store.
- `ex_lsu_op` in LsuOpWidth: [3] 0 = load, 1 = store; [2] unsigned load; [1:0] 00 = byte, x1 = half, 10 = word.
- `ex_store_data` in DataWidth: rs2 value for stores.
- `dmem_req_valid` out 1: memory request valid.
- `dmem_req_ready` in 1: memory accepts the request.
- `dmem_req_addr` out DataWidth: word-aligned address, {addr[31:2], 2'b00}.
- `dmem_req_we` out 1: 1 = write.
- `dmem_req_be` out 4: byte enables.
- `dmem_req_wdata` out DataWidth: replicated store data.
- `dmem_rsp_valid` in 1: read data valid; asserted only for reads.
- `dmem_rsp_rdata` in DataWidth: read word.
- `wb_valid` out 1: MEM/WB packet valid, one-cycle pulse per instruction.
- `wb_rd_en` out 1: write-back enable.
- `wb_rd_addr` out RegAddrWidth: destination register.
- `wb_rd_data` out DataWidth: write-back data.
- `mem_misaligned` out 1: one-cycle pulse that coincides with the `wb_valid` of a misaligned access.

## Operation
- FSM has three states:
  - IDLE: `ex_ready` = 1.
  - REQ: `dmem_req_valid` = 1, with all request fields held stable until the handshake completes.
  - RESP: waits for `dmem_rsp_valid`.
- Accept happens when `ex_valid && ex_ready`. The opcode, byte offset addr[1:0], `rd_addr` and `rd_en` are latched on accept.
- Non-LSU instruction:
  - `wb_*` is registered from the `ex_*` inputs with `wb_rd_data` = `ex_alu_res`.
  - FSM stays in IDLE.
- Misalignment rules:
  - Half access with addr[0] = 1 is misaligned.
  - Word access with addr[1:0] ≠ 0 is misaligned.
  - A misaligned access issues no request. Next cycle: `wb_valid` = 1, `wb_rd_en` = 0, `mem_misaligned` = 1. FSM stays in IDLE.
- Aligned LSU op: IDLE → REQ.
- Store path:
  - SB: `be` = 4'b0001 << off; `wdata` = {4{sd[7:0]}}.
  - SH: `be` = off[1] ? 4'b1100 : 4'b0011; `wdata` = {2{sd[15:0]}}.
  - SW: `be` = 4'b1111; `wdata` = sd.
  - REQ → IDLE on the handshake. Next cycle: `wb_valid` = 1, `wb_rd_en` = 0.
- Load path:
  - Request carries `be` = 4'b1111 and `we` = 0.
  - REQ → RESP on the handshake. RESP → IDLE on `dmem_rsp_valid`.
  - Next cycle, `wb_rd_data` is:
    - Byte: `rdata[8*off +: 8]`.
    - Half: `rdata[16*off[1] +: 16]`.
    - Word: `rdata`.
  - The selected field is sign-extended when bit 2 = 0 and zero-extended when bit 2 = 1.
  - `wb_rd_en` = latched `rd_en`.
- `dmem_rsp_valid` is ignored in IDLE and in REQ.
- Loads to x0 are passed through unchanged; the register file discards them.

## Timing
- Reset values:
  - All outputs are 0, except `ex_ready`, which is 1 because the FSM resets to IDLE.
  - `dmem_req_*` outputs are 0.
- Reset asserted mid-transaction: the transaction is abandoned immediately and no `wb_valid` is produced for it. A response arriving after reset is ignored.
- Latency from accept to `wb_valid`:
  - Non-LSU or misaligned: 1 cycle.
  - Store: handshake cycle + 1, which is a minimum of 2.
  - Load: response cycle + 1, which is a minimum of 3 (accept, REQ with ready, RESP with rsp_valid, then wb).
- Throughput:
  - Non-LSU: one instruction per cycle, back-to-back.
  - `ex_ready` = 0 in REQ and RESP.
- REQ → IDLE or RESP happens on the same edge as the handshake. A new packet can be accepted in the cycle the FSM returns to IDLE.
- `wb_valid` is never asserted in two consecutive cycles for the same instruction.

## Test plan
- ADD result pass-through, plus back-to-back streaming:
  - Stimulus: `ex_alu_res` = 0x1234_5678, rd = 5, `rd_en` = 1, `lsu` = 0.
  - Response: next cycle `wb_valid` = 1 with rd 5 and data 0x1234_5678.
  - Follow with 3 back-to-back non-LSU packets: `ex_ready` stays 1 throughout, and 3 consecutive `wb_valid` pulses.
- SB with stall:
  - Stimulus: addr 0x1003, sd = 0xAABB_CCDD, `dmem_req_ready` held low for 2 cycles.
  - Response: `req_valid` held for 3 cycles with `be` = 4'b1000, `wdata` = 0xDDDD_DDDD and `addr` 0x1000 stable. `ex_ready` = 0 throughout. `wb_valid` with `rd_en` = 0 one cycle after the handshake.
- LH sign-extended:
  - Stimulus: addr 0x2002, rsp `rdata` = 0x8001_7FFF delayed 3 cycles.
  - Response: `wb_rd_data` = 0xFFFF_8001.
- LBU zero-extended:
  - Stimulus: addr 0x2001, `rdata` 0x0000_F100.
  - Response: `wb_rd_data` = 0x0000_00F1.
- Misaligned LW:
  - Stimulus: addr 0x3002.
  - Response: `dmem_req_valid` never asserted. Next cycle `wb_valid` = 1, `mem_misaligned` = 1, `wb_rd_en` = 0.
- Reset during RESP of a load, plus spurious response:
  - Stimulus: assert `rst_n` = 0 while the load is in RESP.
  - Response: all outputs 0 and `ex_ready` = 1 after reset. A late `rsp_valid` produces no `wb_valid`.
  - Also drive a spurious `rsp_valid` in IDLE: it is ignored.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage -- RV32 memory stage.
//
// Takes the EX/MEM packet and produces the MEM/WB packet. Non-memory ops
// pass through one register stage. Loads/stores run one request/response
// transaction on the data-memory port; EX is stalled via ex_ready_o while
// a transaction is outstanding.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   ex_*_i / ex_ready_o    EX/MEM packet in, accept handshake
//   dmem_req_*             memory request (valid/ready handshake)
//   dmem_rsp_*             read response (reads only)
//   wb_*_o                 MEM/WB packet, wb_valid_o is a one-cycle pulse
//   mem_misaligned_o       pulses with wb_valid_o of a misaligned access
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a new packet; non-LSU and misaligned ops finish here
// REQ    | request on the bus, fields held until dmem_req_ready_i
// RESP   | load request accepted, waiting for dmem_rsp_valid_i
module lsu_mem_stage #(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5,
  parameter int LsuOpWidth   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ex_valid_i,
  output logic                    ex_ready_o,
  input  logic                    ex_rd_en_i,
  input  logic [RegAddrWidth-1:0] ex_rd_addr_i,
  input  logic [DataWidth-1:0]    ex_alu_res_i,
  input  logic                    ex_lsu_i,
  input  logic [LsuOpWidth-1:0]   ex_lsu_op_i,
  input  logic [DataWidth-1:0]    ex_store_data_i,
  output logic                    dmem_req_valid_o,
  input  logic                    dmem_req_ready_i,
  output logic [DataWidth-1:0]    dmem_req_addr_o,
  output logic                    dmem_req_we_o,
  output logic [3:0]              dmem_req_be_o,
  output logic [DataWidth-1:0]    dmem_req_wdata_o,
  input  logic                    dmem_rsp_valid_i,
  input  logic [DataWidth-1:0]    dmem_rsp_rdata_i,
  output logic                    wb_valid_o,
  output logic                    wb_rd_en_o,
  output logic [RegAddrWidth-1:0] wb_rd_addr_o,
  output logic [DataWidth-1:0]    wb_rd_data_o,
  output logic                    mem_misaligned_o
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              ld_op_q, ld_op_d;
  logic [1:0]              off_q, off_d;
  logic [RegAddrWidth-1:0] rd_addr_q, rd_addr_d;
  logic                    rd_en_q, rd_en_d;
  logic [DataWidth-1:0]    addr_q, addr_d;
  logic                    we_q, we_d;
  logic [3:0]              be_q, be_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;

  logic                    wb_valid_q, wb_valid_d;
  logic                    wb_rd_en_q, wb_rd_en_d;
  logic [RegAddrWidth-1:0] wb_rd_addr_q, wb_rd_addr_d;
  logic [DataWidth-1:0]    wb_rd_data_q, wb_rd_data_d;
  logic                    mis_q, mis_d;

  logic [1:0]           ex_off;
  logic                 ex_misaligned;
  logic [3:0]           st_be;
  logic [DataWidth-1:0] st_wdata;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic                 ld_signed;
  logic [DataWidth-1:0] ld_data;

  assign ex_off = ex_alu_res_i[1:0];
  // op[0] set means half (x1), op[1:0] == 10 means word, 00 means byte.
  assign ex_misaligned = (ex_lsu_op_i[0] && ex_off[0]) ||
                         ((ex_lsu_op_i[1:0] == 2'b10) && (ex_off != 2'b00));

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_store_data_i;
    if (ex_lsu_op_i[0]) begin
      st_be    = ex_off[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{ex_store_data_i[15:0]}};
    end else if (!ex_lsu_op_i[1]) begin
      st_be    = 4'b0001 << ex_off;
      st_wdata = {4{ex_store_data_i[7:0]}};
    end
  end

  assign ld_byte   = dmem_rsp_rdata_i[{off_q, 3'b000} +: 8];
  assign ld_half   = off_q[1] ? dmem_rsp_rdata_i[31:16] : dmem_rsp_rdata_i[15:0];
  assign ld_signed = ~ld_op_q[2];

  always_comb begin
    ld_data = dmem_rsp_rdata_i;
    if (ld_op_q[1:0] == 2'b00) begin
      ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
    end else if (ld_op_q[0]) begin
      ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_op_d      = ld_op_q;
    off_d        = off_q;
    rd_addr_d    = rd_addr_q;
    rd_en_d      = rd_en_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    wb_valid_d   = 1'b0;
    wb_rd_en_d   = 1'b0;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_rd_data_d = wb_rd_data_q;
    mis_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ex_valid_i) begin
          if (!ex_lsu_i) begin
            wb_valid_d   = 1'b1;
            wb_rd_en_d   = ex_rd_en_i;
            wb_rd_addr_d = ex_rd_addr_i;
            wb_rd_data_d = ex_alu_res_i;
          end else if (ex_misaligned) begin
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = ex_rd_addr_i;
            wb_rd_data_d = '0;
            mis_d        = 1'b1;
          end else begin
            state_d   = StReq;
            ld_op_d   = ex_lsu_op_i[2:0];
            off_d     = ex_off;
            rd_addr_d = ex_rd_addr_i;
            rd_en_d   = ex_rd_en_i;
            addr_d    = {ex_alu_res_i[DataWidth-1:2], 2'b00};
            we_d      = ex_lsu_op_i[3];
            be_d      = ex_lsu_op_i[3] ? st_be : 4'b1111;
            wdata_d   = ex_lsu_op_i[3] ? st_wdata : '0;
          end
        end
      end
      StReq: begin
        if (dmem_req_ready_i) begin
          if (we_q) begin
            state_d      = StIdle;
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = rd_addr_q;
            wb_rd_data_d = '0;
          end else begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (dmem_rsp_valid_i) begin
          state_d      = StIdle;
          wb_valid_d   = 1'b1;
          wb_rd_en_d   = rd_en_q;
          wb_rd_addr_d = rd_addr_q;
          wb_rd_data_d = ld_data;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      ld_op_q      <= '0;
      off_q        <= '0;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_en_q   <= 1'b0;
      wb_rd_addr_q <= '0;
      wb_rd_data_q <= '0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_op_q      <= ld_op_d;
      off_q        <= off_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_en_q   <= wb_rd_en_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_data_q <= wb_rd_data_d;
      mis_q        <= mis_d;
    end
  end

  assign ex_ready_o       = (state_q == StIdle);
  assign dmem_req_valid_o = (state_q == StReq);
  // Request fields read as zero outside REQ so stale packets never show on the bus.
  assign dmem_req_addr_o  = dmem_req_valid_o ? addr_q  : '0;
  assign dmem_req_we_o    = dmem_req_valid_o & we_q;
  assign dmem_req_be_o    = dmem_req_valid_o ? be_q    : 4'b0000;
  assign dmem_req_wdata_o = dmem_req_valid_o ? wdata_q : '0;

  assign wb_valid_o       = wb_valid_q;
  assign wb_rd_en_o       = wb_rd_en_q;
  assign wb_rd_addr_o     = wb_rd_addr_q;
  assign wb_rd_data_o     = wb_rd_data_q;
  assign mem_misaligned_o = mis_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a write-back scoreboard.
module tb_lsu_mem_stage;

  typedef struct {
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] data;
    logic        cmp_data;
    logic        mis;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_rd_en, ex_lsu;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_alu_res, ex_store_data;
  logic [3:0]  ex_lsu_op;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        wb_valid, wb_rd_en, mis;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  wb_exp_t exp_q[$];

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .ex_rd_en_i(ex_rd_en), .ex_rd_addr_i(ex_rd_addr),
    .ex_alu_res_i(ex_alu_res), .ex_lsu_i(ex_lsu),
    .ex_lsu_op_i(ex_lsu_op), .ex_store_data_i(ex_store_data),
    .dmem_req_valid_o(req_valid), .dmem_req_ready_i(req_ready),
    .dmem_req_addr_o(req_addr), .dmem_req_we_o(req_we),
    .dmem_req_be_o(req_be), .dmem_req_wdata_o(req_wdata),
    .dmem_rsp_valid_i(rsp_valid), .dmem_rsp_rdata_i(rsp_rdata),
    .wb_valid_o(wb_valid), .wb_rd_en_o(wb_rd_en),
    .wb_rd_addr_o(wb_rd_addr), .wb_rd_data_o(wb_rd_data),
    .mem_misaligned_o(mis)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Waits up to 'budget' cycles for wb_valid, then pops and compares the scoreboard head.
  task automatic check_wb(input string tag, input int budget);
    wb_exp_t e;
    logic found = 1'b0;
    for (int c = 0; c <= budget; c++) begin
      if (wb_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (c < budget) @(negedge clk);
    end
    chk({tag, " wb_valid"}, {31'd0, found}, 32'd1);
    if (found) begin
      if (exp_q.size() == 0) begin
        chk({tag, " scoreboard nonempty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk({tag, " wb_rd_en"},   {31'd0, wb_rd_en},   {31'd0, e.rd_en});
        chk({tag, " wb_rd_addr"}, {27'd0, wb_rd_addr}, {27'd0, e.rd_addr});
        chk({tag, " misaligned"}, {31'd0, mis},        {31'd0, e.mis});
        if (e.cmp_data) chk({tag, " wb_rd_data"}, wb_rd_data, e.data);
      end
    end
  endtask

  task automatic drive_pkt(input logic lsu, input logic [3:0] op, input logic [31:0] alu,
                           input logic [31:0] sd, input logic [4:0] rd, input logic rd_en);
    ex_valid      = 1'b1;
    ex_lsu        = lsu;
    ex_lsu_op     = op;
    ex_alu_res    = alu;
    ex_store_data = sd;
    ex_rd_addr    = rd;
    ex_rd_en      = rd_en;
  endtask

  task automatic do_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [4:0] rd, input int stall,
                          input logic [3:0] ebe, input logic [31:0] ewdata);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    req_ready = 1'b0;
    drive_pkt(1'b1, op, addr, sd, rd, 1'b1);
    exp_q.push_back('{1'b0, rd, 32'd0, 1'b0, 1'b0});
    @(negedge clk);
    ex_valid = 1'b0;
    for (int k = 0; k <= stall; k++) begin
      chk({tag, " req_valid"}, {31'd0, req_valid}, 32'd1);
      chk({tag, " req_addr"},  req_addr, waddr);
      chk({tag, " req_be"},    {28'd0, req_be}, {28'd0, ebe});
      chk({tag, " req_wdata"}, req_wdata, ewdata);
      chk({tag, " req_we"},    {31'd0, req_we}, 32'd1);
      chk({tag, " ex_ready"},  {31'd0, ex_ready}, 32'd0);
      chk({tag, " early wb"},  {31'd0, wb_valid}, 32'd0);
      if (k == stall) req_ready = 1'b1;
      @(negedge clk);
    end
    req_ready = 1'b0;
    chk({tag, " req dropped"}, {31'd0, req_valid}, 32'd0);
    check_wb(tag, 0);
    @(negedge clk);
    chk({tag, " single pulse"}, {31'd0, wb_valid}, 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] rdata, input int delay,
                         input logic [31:0] edata);
    drive_pkt(1'b1, op, addr, 32'hDEAD_BEEF, rd, 1'b1);
    exp_q.push_back('{1'b1, rd, edata, 1'b1, 1'b0});
    req_ready = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk({tag, " req_valid"}, {31'd0, req_valid}, 32'd1);
    chk({tag, " req_we"},    {31'd0, req_we}, 32'd0);
    chk({tag, " req_be"},    {28'd0, req_be}, 32'h0000_000F);
    chk({tag, " req_addr"},  req_addr, {addr[31:2], 2'b00});
    // A response during REQ must be ignored.
    rsp_valid = 1'b1;
    rsp_rdata = ~rdata;
    @(negedge clk);
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    chk({tag, " req handshake"}, {31'd0, req_valid}, 32'd0);
    repeat (delay) begin
      chk({tag, " wait ex_ready"}, {31'd0, ex_ready}, 32'd0);
      chk({tag, " wait wb"},       {31'd0, wb_valid}, 32'd0);
      @(negedge clk);
    end
    rsp_valid = 1'b1;
    rsp_rdata = rdata;
    @(negedge clk);
    rsp_valid = 1'b0;
    check_wb(tag, 0);
    @(negedge clk);
    chk({tag, " single pulse"}, {31'd0, wb_valid}, 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " ex_ready"},   {31'd0, ex_ready},   32'd1);
    chk({tag, " req_valid"},  {31'd0, req_valid},  32'd0);
    chk({tag, " req_addr"},   req_addr,            32'd0);
    chk({tag, " req_we"},     {31'd0, req_we},     32'd0);
    chk({tag, " req_be"},     {28'd0, req_be},     32'd0);
    chk({tag, " req_wdata"},  req_wdata,           32'd0);
    chk({tag, " wb_valid"},   {31'd0, wb_valid},   32'd0);
    chk({tag, " wb_rd_en"},   {31'd0, wb_rd_en},   32'd0);
    chk({tag, " wb_rd_addr"}, {27'd0, wb_rd_addr}, 32'd0);
    chk({tag, " wb_rd_data"}, wb_rd_data,          32'd0);
    chk({tag, " misaligned"}, {31'd0, mis},        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] alus [4];
    logic [4:0]  rds  [4];
    alus = '{32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF, 32'hCAFE_0000};
    rds  = '{5'd5, 5'd6, 5'd0, 5'd31};

    rst_n = 1'b0; ex_valid = 1'b0; ex_lsu = 1'b0; ex_lsu_op = 4'd0;
    ex_alu_res = '0; ex_store_data = '0; ex_rd_addr = '0; ex_rd_en = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // ADD pass-through followed by three back-to-back non-LSU packets.
    for (int i = 0; i < 4; i++) begin
      chk("stream ex_ready", {31'd0, ex_ready}, 32'd1);
      drive_pkt(1'b0, 4'd0, alus[i], 32'd0, rds[i], (i != 2));
      exp_q.push_back('{(i != 2), rds[i], alus[i], 1'b1, 1'b0});
      @(negedge clk);
      check_wb("stream", 0);
    end
    ex_valid = 1'b0;
    @(negedge clk);
    chk("stream end wb", {31'd0, wb_valid}, 32'd0);

    do_store("sb_stall", 4'b1000, 32'h0000_1003, 32'hAABB_CCDD, 5'd7, 2, 4'b1000, 32'hDDDD_DDDD);
    do_store("sh_hi",    4'b1001, 32'h0000_1006, 32'h1122_3344, 5'd8, 0, 4'b1100, 32'h3344_3344);
    do_store("sw",       4'b1010, 32'h0000_1008, 32'h0BAD_F00D, 5'd9, 1, 4'b1111, 32'h0BAD_F00D);

    do_load("lh_sext",  4'b0001, 32'h0000_2002, 5'd9,  32'h8001_7FFF, 3, 32'hFFFF_8001);
    do_load("lbu_zext", 4'b0100, 32'h0000_2001, 5'd10, 32'h0000_F100, 0, 32'h0000_00F1);
    do_load("lb_sext",  4'b0000, 32'h0000_2003, 5'd11, 32'h8012_3456, 1, 32'hFFFF_FF80);
    do_load("lhu_lo",   4'b0101, 32'h0000_2000, 5'd12, 32'h1234_8765, 0, 32'h0000_8765);
    do_load("lw",       4'b0010, 32'h0000_2004, 5'd13, 32'hA5A5_5A5A, 2, 32'hA5A5_5A5A);

    // Misaligned word and half accesses.
    drive_pkt(1'b1, 4'b0010, 32'h0000_3002, 32'd0, 5'd11, 1'b1);
    exp_q.push_back('{1'b0, 5'd11, 32'd0, 1'b0, 1'b1});
    @(negedge clk);
    ex_valid = 1'b0;
    chk("mis_lw no req", {31'd0, req_valid}, 32'd0);
    check_wb("mis_lw", 0);
    @(negedge clk);
    chk("mis_lw no req later", {31'd0, req_valid}, 32'd0);
    chk("mis_lw pulse",        {31'd0, mis},       32'd0);
    chk("mis_lw ex_ready",     {31'd0, ex_ready},  32'd1);
    drive_pkt(1'b1, 4'b1001, 32'h0000_3001, 32'd0, 5'd12, 1'b1);
    exp_q.push_back('{1'b0, 5'd12, 32'd0, 1'b0, 1'b1});
    @(negedge clk);
    ex_valid = 1'b0;
    chk("mis_sh no req", {31'd0, req_valid}, 32'd0);
    check_wb("mis_sh", 0);
    @(negedge clk);

    // Reset while a load waits in RESP; the late response must be dropped.
    drive_pkt(1'b1, 4'b0010, 32'h0000_4000, 32'd0, 5'd14, 1'b1);
    req_ready = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    req_ready = 1'b0;
    chk("rst_resp in resp", {31'd0, ex_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_state("rst_resp");
    @(negedge clk);
    rst_n = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 32'h1357_9BDF;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("late rsp wb", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    chk("late rsp wb2", {31'd0, wb_valid}, 32'd0);

    // Spurious responses in IDLE.
    rsp_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle rsp wb",       {31'd0, wb_valid},  32'd0);
      chk("idle rsp ex_ready", {31'd0, ex_ready},  32'd1);
      chk("idle rsp req",      {31'd0, req_valid}, 32'd0);
    end
    rsp_valid = 1'b0;

    // Pass-through still works after the abandoned transaction.
    drive_pkt(1'b0, 4'd0, 32'h0F0F_0F0F, 32'd0, 5'd3, 1'b1);
    exp_q.push_back('{1'b1, 5'd3, 32'h0F0F_0F0F, 1'b1, 1'b0});
    @(negedge clk);
    ex_valid = 1'b0;
    check_wb("post_rst add", 0);
    @(negedge clk);

    chk("scoreboard drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
